instr_fetch: RTL



---
 rtl/instr_fetch.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS IF stage owning the PC, a one-entry skid buffer and the IF/ID register.
// Define IF_PERF_EN to add the fetch/bubble performance counters.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
module instr_fetch #(
  parameter logic [`ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int                     PC_STEP  = 4
) (
  input  logic                    clk_87,
  input  logic                    rst_87,
  output logic                    imem_req_87,
  output logic [`ADDR_WIDTH-1:0]  imem_addr_87,
  input  logic                    imem_ready_87,
  input  logic [`INSTR_WIDTH-1:0] imem_data_87,
  input  logic                    stall_87,
  input  logic                    branch_flag_87,
  input  logic [`ADDR_WIDTH-1:0]  branch_pc_87,
  input  logic                    halt_87,
  output logic [`INSTR_WIDTH-1:0] instr_87,
  output logic [`ADDR_WIDTH-1:0]  pc_next_87,
  output logic                    valid_87,
  output logic                    halted_87
`ifdef IF_PERF_EN
  ,
  output logic [31:0]             fetch_cnt_87,
  output logic [31:0]             bubble_cnt_87
`endif
);
  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_HALT} state_t;
  localparam logic [`ADDR_WIDTH-1:0] STEP = `ADDR_WIDTH'(PC_STEP);
  state_t                   state_q, state_d;
  logic [`ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [`INSTR_WIDTH-1:0]  skid_instr_q, skid_instr_d;
  logic [`ADDR_WIDTH-1:0]   skid_pc_q, skid_pc_d;
  logic [`INSTR_WIDTH-1:0]  instr_q, instr_d;
  logic [`ADDR_WIDTH-1:0]   pc_next_q, pc_next_d;
  logic                     valid_q, valid_d;
  logic                     load_valid, load_bubble;
  logic [`ADDR_WIDTH-1:0]   pc_inc, target;
  assign pc_inc       = pc_q + STEP;
  assign target       = {branch_pc_87[`ADDR_WIDTH-1:2], 2'b00};
  assign imem_req_87  = (state_q == S_FETCH) && !rst_87;
  assign imem_addr_87 = pc_q;
  assign instr_87     = instr_q;
  assign pc_next_87   = pc_next_q;
  assign valid_87     = valid_q;
  assign halted_87    = state_q == S_HALT;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    pc_next_d    = pc_next_q;
    valid_d      = valid_q;
    load_valid   = 1'b0;
    load_bubble  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (stall_87) begin
          if (imem_ready_87) begin
            pc_d         = pc_inc;
            skid_instr_d = imem_data_87;
            skid_pc_d    = pc_inc;
            state_d      = S_HOLD;
          end
        end else if (halt_87) begin
          instr_d   = '0;
          pc_next_d = '0;
          valid_d   = 1'b0;
          state_d   = S_HALT;
        end else if (branch_flag_87) begin
          pc_d        = target;
          instr_d     = '0;
          pc_next_d   = '0;
          valid_d     = 1'b0;
          load_bubble = 1'b1;
        end else if (imem_ready_87) begin
          pc_d       = pc_inc;
          instr_d    = imem_data_87;
          pc_next_d  = pc_inc;
          valid_d    = 1'b1;
          load_valid = 1'b1;
        end else begin
          instr_d     = '0;
          pc_next_d   = '0;
          valid_d     = 1'b0;
          load_bubble = 1'b1;
        end
      end
      S_HOLD: begin
        if (stall_87) begin
          state_d = S_HOLD;
        end else if (halt_87) begin
          instr_d   = '0;
          pc_next_d = '0;
          valid_d   = 1'b0;
          state_d   = S_HALT;
        end else if (branch_flag_87) begin
          // the skid entry lies on the wrong path; drop it and refetch at target
          pc_d         = target;
          skid_instr_d = '0;
          skid_pc_d    = '0;
          instr_d      = '0;
          pc_next_d    = '0;
          valid_d      = 1'b0;
          load_bubble  = 1'b1;
          state_d      = S_FETCH;
        end else begin
          instr_d    = skid_instr_q;
          pc_next_d  = skid_pc_q;
          valid_d    = 1'b1;
          load_valid = 1'b1;
          state_d    = S_FETCH;
        end
      end
      default: begin
        instr_d   = '0;
        pc_next_d = '0;
        valid_d   = 1'b0;
        state_d   = S_HALT;
      end
    endcase
  end
  always_ff @(posedge clk_87) begin
    if (rst_87) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      instr_q      <= '0;
      pc_next_q    <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pc_next_q    <= pc_next_d;
      valid_q      <= valid_d;
    end
  end
`ifdef IF_PERF_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;
  assign fetch_cnt_87  = fetch_cnt_q;
  assign bubble_cnt_87 = bubble_cnt_q;
  always_ff @(posedge clk_87) begin
    if (rst_87) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_q + {31'd0, load_valid};
      bubble_cnt_q <= bubble_cnt_q + {31'd0, load_bubble};
    end
  end
`else
  logic unused_perf;
  assign unused_perf = load_valid ^ load_bubble;
`endif
endmodule
